// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state types for the on-chip memory responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_mem_bank.sv
// Word-addressed memory: one byte-enabled synchronous write port, one combinational read port.
module axi_mem_bank #(
  parameter int MEM_AWIDTH = 12,
  parameter int DWIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0]     wdata,
  input  logic [DWIDTH/8-1:0]   wstrb,
  input  logic [MEM_AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0]     rdata
);

  logic [DWIDTH-1:0] mem [1 << MEM_AWIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < DWIDTH / 8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by axi_mem_bank; independent single-outstanding read and write engines.
// Define AXI_MEM_RANGE_CHECK_EN to answer DECERR for beats beyond the memory instead of wrapping.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int MEM_AWIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              arid,
  input  logic [AXI_AWIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic [3:0]              rid,
  output logic [AXI_DWIDTH-1:0]   rdata,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    rlast,
  output logic [1:0]              rresp,
  input  logic [3:0]              awid,
  input  logic [AXI_AWIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [3:0]              wid,
  input  logic [AXI_DWIDTH-1:0]   wdata,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    wlast,
  input  logic [AXI_DWIDTH/8-1:0] wstrb,
  output logic [3:0]              bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  function automatic logic [AXI_AWIDTH-1:0] next_addr(input logic [AXI_AWIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    if (burst == BURST_FIXED) return a;
    return a + (AXI_AWIDTH'(1) << size);
  endfunction

  logic unused_wid;
  assign unused_wid = ^wid;

  // Write engine
  w_state_t              w_state, w_next;
  logic [3:0]            w_id;
  logic [AXI_AWIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst, w_resp;
  logic                  aw_hs, w_hs, w_last_beat, w_oor, mem_we;

  // Read engine
  r_state_t              r_state, r_next;
  logic [3:0]            r_id;
  logic [AXI_AWIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst, rresp_q;
  logic [AXI_DWIDTH-1:0] rdata_q, mem_rdata;
  logic                  ar_hs, r_last_beat, r_load, r_oor;

`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam logic [AXI_AWIDTH-1:0] MEM_LIMIT = AXI_AWIDTH'(4) << MEM_AWIDTH;
  assign w_oor = (w_addr >= MEM_LIMIT);
  assign r_oor = (r_addr >= MEM_LIMIT);
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  axi_mem_bank #(
    .MEM_AWIDTH(MEM_AWIDTH),
    .DWIDTH    (AXI_DWIDTH)
  ) u_bank (
    .clk  (clk),
    .we   (mem_we),
    .waddr(w_addr[MEM_AWIDTH+1:2]),
    .wdata(wdata),
    .wstrb(wstrb),
    .raddr(r_addr[MEM_AWIDTH+1:2]),
    .rdata(mem_rdata)
  );

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign w_last_beat = (w_cnt == w_len);
  assign mem_we      = w_hs && !w_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
    if (rst) begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_resp  <= RESP_OKAY;
    end else if (aw_hs) begin
      w_id    <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_cnt   <= '0;
      w_resp  <= RESP_OKAY;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_size, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      // DECERR is sticky and outranks SLVERR
      if (w_oor) w_resp <= RESP_DECERR;
      else if ((wlast != w_last_beat) && (w_resp != RESP_DECERR)) w_resp <= RESP_SLVERR;
    end
  end

  assign bid   = w_id;
  assign bresp = bvalid ? w_resp : RESP_OKAY;

  assign ar_hs       = arvalid && arready;
  assign r_last_beat = (r_cnt == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    r_load  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_FETCH;
      end
      R_FETCH: begin
        r_load = 1'b1;
        r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        // Accepting a non-final beat prefetches the next word on the same edge
        if (rready) begin
          if (r_last_beat) r_next = R_IDLE;
          else             r_load = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
    if (rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      r_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      r_id    <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= '0;
    end else if (r_load) begin
      rdata_q <= r_oor ? '0 : mem_rdata;
      rresp_q <= r_oor ? RESP_DECERR : RESP_OKAY;
      r_addr  <= next_addr(r_addr, r_size, r_burst);
      if (r_state == R_DATA) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign rid   = r_id;
  assign rdata = rdata_q;
  assign rresp = rvalid ? rresp_q : RESP_OKAY;
  assign rlast = rvalid && r_last_beat;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized self-checking bench for axi_mem_responder against a word-array reference model.
module tb_axi_mem_responder;

  logic        clk, rst;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [4096];

  axi_mem_responder #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .MEM_AWIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wid(wid), .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast), .wstrb(wstrb),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic beat_oor(input logic [31:0] a);
`ifdef AXI_MEM_RANGE_CHECK_EN
    return a >= 32'h4000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i,
                                            input logic [1:0] burst, input logic [2:0] size);
    if (burst == 2'b00) return base;
    return base + 32'(i) * (32'd1 << size);
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [31:0] d[$], input logic [3:0] s[$],
                             input int last_at, output logic [1:0] exp_resp);
    bit dec = 0, slv = 0;
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a;
      a = beat_addr(addr, i, burst, size);
      if ((i == last_at) != (i == len)) slv = 1;
      if (beat_oor(a)) dec = 1;
      else for (int b = 0; b < 4; b++)
        if (s[i][b]) model_mem[(a >> 2) % 4096][8*b +: 8] = d[i][8*b +: 8];
    end
    exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endtask

  task automatic model_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, output logic [31:0] ed[$], output logic [1:0] er[$]);
    ed = {};
    er = {};
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a;
      a = beat_addr(addr, i, burst, size);
      ed.push_back(beat_oor(a) ? 32'h0 : model_mem[(a >> 2) % 4096]);
      er.push_back(beat_oor(a) ? 2'b11 : 2'b00);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [31:0] d[$], input logic [3:0] s[$], input int last_at,
                          output logic [1:0] resp, output logic [3:0] obid, output bit tmo);
    int n;
    tmo = 0;
    awaddr = addr; awid = id; awlen = 8'(len); awburst = burst; awsize = size; awvalid = 1;
    n = 0;
    while (!awready && n < 300) begin @(negedge clk); n++; end
    if (!awready) tmo = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0;
    for (int i = 0; i <= len; i++) begin
      wdata = d[i]; wstrb = s[i]; wlast = (i == last_at); wid = id; wvalid = 1;
      n = 0;
      while (!wready && n < 300) begin @(negedge clk); n++; end
      if (!wready) tmo = 1;
      @(posedge clk); @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    n = 0;
    while (!bvalid && n < 300) begin @(negedge clk); n++; end
    if (!bvalid) tmo = 1;
    resp = bresp; obid = bid;
    bready = 1;
    @(posedge clk); @(negedge clk);
    bready = 0;
  endtask

  // mode: 0 = rready always high, 1 = toggle 1010..., 2 = random
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input int mode,
                         output logic [31:0] dq[$], output logic [1:0] rq[$], output logic lq[$],
                         output logic [3:0] orid, output int lat, output int unstable, output bit tmo);
    int n, cyc, k;
    bit held;
    logic [31:0] hd;
    logic hl;
    dq = {}; rq = {}; lq = {};
    tmo = 0; lat = -1; unstable = 0; held = 0; orid = 'x; k = 0;
    araddr = addr; arid = id; arlen = 8'(len); arburst = burst; arsize = size; arvalid = 1;
    n = 0;
    while (!arready && n < 300) begin @(negedge clk); n++; end
    if (!arready) tmo = 1;
    @(posedge clk); @(negedge clk);
    arvalid = 0;
    cyc = 1;
    while (dq.size() <= len && cyc < 2000) begin
      logic rr;
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      k++;
      rready = rr;
      if (rvalid) begin
        if (lat < 0) begin lat = cyc; orid = rid; end
        if (held && (rdata !== hd || rlast !== hl)) unstable++;
        if (rr) begin
          dq.push_back(rdata); rq.push_back(rresp); lq.push_back(rlast); held = 0;
        end else begin
          hd = rdata; hl = rlast; held = 1;
        end
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    rready = 0;
    if (dq.size() <= len) tmo = 1;
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [31:0] dq[$], input logic [1:0] rq[$], input logic lq[$]);
    logic [31:0] ed[$];
    logic [1:0]  er[$];
    model_read(addr, len, burst, size, ed, er);
    for (int i = 0; i <= len && i < dq.size(); i++) begin
      n_checks++;
      if (dq[i] !== ed[i] || rq[i] !== er[i] || lq[i] !== (i == len)) begin
        n_fail++;
        $display("FAIL %s beat %0d: got data=%h resp=%0d last=%b, expected data=%h resp=%0d last=%b",
                 tag, i, dq[i], rq[i], lq[i], ed[i], er[i], (i == len));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0; wlast = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wid = 0; wdata = 0; wstrb = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({arready, awready, rvalid, bvalid, wready, rlast, rdata, rid, bid, rresp, bresp} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ar=%b aw=%b rv=%b bv=%b w=%b rl=%b rdata=%h rid=%h bid=%h rresp=%0d bresp=%0d, expected all 0",
               arready, awready, rvalid, bvalid, wready, rlast, rdata, rid, bid, rresp, bresp);
    end
    rst = 0;
    #1;
    n_checks++;
    if (arready !== 1'b1 || awready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got arready=%b awready=%b, expected 1 1", arready, awready);
    end
    @(negedge clk);
  endtask

  task automatic test_preload;
    logic [31:0] d[$];
    logic [3:0]  s[$];
    logic [1:0]  er, resp;
    logic [3:0]  ob;
    bit tmo;
    for (int k = 0; k < 16; k++) begin
      d = {}; s = {};
      for (int i = 0; i < 256; i++) begin d.push_back($urandom); s.push_back(4'hF); end
      model_write(32'(k * 1024), 255, 2'b01, 3'd2, d, s, 255, er);
      do_write(32'(k * 1024), 4'(k), 255, 2'b01, 3'd2, d, s, 255, resp, ob, tmo);
      n_checks++;
      if (tmo || resp !== er || ob !== 4'(k)) begin
        n_fail++;
        $display("FAIL preload_%0d: got resp=%0d bid=%0d tmo=%b, expected resp=%0d bid=%0d", k, resp, ob, tmo, er, k);
      end
    end
  endtask

  task automatic test_incr_burst;
    logic [31:0] d[$], dq[$];
    logic [3:0]  s[$];
    logic [1:0]  er, resp, rq[$];
    logic        lq[$];
    logic [3:0]  ob, orid;
    int lat, unst;
    bit tmo;
    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    s = '{4'hF, 4'hF, 4'hF, 4'hF};
    model_write(32'h100, 3, 2'b01, 3'd2, d, s, 3, er);
    do_write(32'h100, 4'h5, 3, 2'b01, 3'd2, d, s, 3, resp, ob, tmo);
    n_checks++;
    if (tmo || resp !== 2'b00 || ob !== 4'h5) begin
      n_fail++;
      $display("FAIL incr_bresp: got resp=%0d bid=%0d tmo=%b, expected resp=0 bid=5", resp, ob, tmo);
    end
    do_read(32'h100, 4'h9, 3, 2'b01, 3'd2, 0, dq, rq, lq, orid, lat, unst, tmo);
    n_checks++;
    if (tmo || lat != 2 || orid !== 4'h9) begin
      n_fail++;
      $display("FAIL incr_latency: got latency=%0d rid=%0d tmo=%b, expected latency=2 rid=9", lat, orid, tmo);
    end
    for (int i = 0; i < 4 && i < dq.size(); i++) begin
      n_checks++;
      if (dq[i] !== 32'hA0 + 32'(i) || lq[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL incr_read beat %0d: got data=%h last=%b, expected data=%h last=%b", i, dq[i], lq[i], 32'hA0 + 32'(i), (i == 3));
      end
    end
  endtask

  task automatic test_strobe;
    logic [31:0] d[$], dq[$];
    logic [3:0]  s[$];
    logic [1:0]  er, resp, rq[$];
    logic        lq[$];
    logic [3:0]  ob, orid;
    int lat, unst;
    bit tmo;
    d = '{32'h11223344}; s = '{4'hF};
    model_write(32'h40, 0, 2'b01, 3'd2, d, s, 0, er);
    do_write(32'h40, 4'h1, 0, 2'b01, 3'd2, d, s, 0, resp, ob, tmo);
    d = '{32'h0000FF00}; s = '{4'b0010};
    model_write(32'h40, 0, 2'b01, 3'd2, d, s, 0, er);
    do_write(32'h40, 4'h2, 0, 2'b01, 3'd2, d, s, 0, resp, ob, tmo);
    do_read(32'h40, 4'h3, 0, 2'b01, 3'd2, 0, dq, rq, lq, orid, lat, unst, tmo);
    n_checks++;
    if (tmo || dq.size() < 1 || dq[0] !== 32'h1122FF44) begin
      n_fail++;
      $display("FAIL strobe_merge: got %h tmo=%b, expected 1122ff44", (dq.size() > 0) ? dq[0] : 32'hx, tmo);
    end
  endtask

  task automatic test_fixed_and_slverr;
    logic [31:0] d[$], dq[$];
    logic [3:0]  s[$];
    logic [1:0]  er, resp, rq[$];
    logic        lq[$];
    logic [3:0]  ob, orid;
    int lat, unst;
    bit tmo;
    d = '{32'd1, 32'd2, 32'd3}; s = '{4'hF, 4'hF, 4'hF};
    model_write(32'h80, 2, 2'b00, 3'd2, d, s, 2, er);
    do_write(32'h80, 4'h4, 2, 2'b00, 3'd2, d, s, 2, resp, ob, tmo);
    do_read(32'h80, 4'h4, 0, 2'b01, 3'd2, 0, dq, rq, lq, orid, lat, unst, tmo);
    n_checks++;
    if (tmo || resp !== 2'b00 || dq.size() < 1 || dq[0] !== 32'd3) begin
      n_fail++;
      $display("FAIL fixed_burst: got data=%h bresp=%0d tmo=%b, expected data=3 bresp=0", (dq.size() > 0) ? dq[0] : 32'hx, resp, tmo);
    end
    d = '{32'hC0FFEE00, 32'hC0FFEE01}; s = '{4'hF, 4'hF};
    model_write(32'h300, 1, 2'b01, 3'd2, d, s, 0, er);
    do_write(32'h300, 4'h6, 1, 2'b01, 3'd2, d, s, 0, resp, ob, tmo);
    n_checks++;
    if (tmo || resp !== 2'b10 || ob !== 4'h6) begin
      n_fail++;
      $display("FAIL slverr_early_wlast: got bresp=%0d bid=%0d tmo=%b, expected bresp=2 bid=6", resp, ob, tmo);
    end
    do_read(32'h300, 4'h6, 1, 2'b01, 3'd2, 0, dq, rq, lq, orid, lat, unst, tmo);
    check_read("slverr_readback", 32'h300, 1, 2'b01, 3'd2, dq, rq, lq);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d[$], dq[$], dq2[$];
    logic [3:0]  s[$];
    logic [1:0]  er, resp, rq[$], rq2[$];
    logic        lq[$], lq2[$];
    logic [3:0]  ob, orid;
    int lat, unst;
    bit tmo, tmo_w;
    do_read(32'h200, 4'h7, 7, 2'b01, 3'd2, 1, dq, rq, lq, orid, lat, unst, tmo);
    n_checks++;
    if (tmo || unst != 0 || dq.size() != 8) begin
      n_fail++;
      $display("FAIL toggle_rready: got beats=%0d unstable=%0d tmo=%b, expected beats=8 unstable=0", dq.size(), unst, tmo);
    end
    check_read("toggle_rready", 32'h200, 7, 2'b01, 3'd2, dq, rq, lq);
    d = {}; s = {};
    for (int i = 0; i < 16; i++) begin d.push_back($urandom); s.push_back(4'hF); end
    model_write(32'h600, 15, 2'b01, 3'd2, d, s, 15, er);
    fork
      do_write(32'h600, 4'hA, 15, 2'b01, 3'd2, d, s, 15, resp, ob, tmo_w);
      do_read(32'h200, 4'hB, 7, 2'b01, 3'd2, 1, dq, rq, lq, orid, lat, unst, tmo);
    join
    n_checks++;
    if (tmo || tmo_w || unst != 0 || resp !== er || ob !== 4'hA) begin
      n_fail++;
      $display("FAIL concurrent: got bresp=%0d bid=%0d unstable=%0d tmo=%b/%b, expected bresp=%0d bid=10 unstable=0",
               resp, ob, unst, tmo_w, tmo, er);
    end
    check_read("concurrent_read", 32'h200, 7, 2'b01, 3'd2, dq, rq, lq);
    do_read(32'h600, 4'hB, 15, 2'b01, 3'd2, 0, dq2, rq2, lq2, orid, lat, unst, tmo);
    check_read("concurrent_write", 32'h600, 15, 2'b01, 3'd2, dq2, rq2, lq2);
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] dq[$];
    logic [1:0]  rq[$];
    logic        lq[$];
    logic [3:0]  orid;
    int n, acc, lat, unst;
    bit tmo;
    araddr = 32'h100; arid = 4'h2; arlen = 8'd7; arburst = 2'b01; arsize = 3'd2; arvalid = 1;
    n = 0;
    while (!arready && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    arvalid = 0; rready = 1; acc = 0; n = 0;
    while (!(rvalid && acc == 2) && n < 50) begin
      if (rvalid) acc++;
      @(posedge clk); @(negedge clk);
      n++;
    end
    rst = 1;
    #1;
    n_checks++;
    if (n >= 50 || rvalid !== 1'b0 || arready !== 1'b0 || awready !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: got rvalid=%b arready=%b awready=%b rdata=%h reached=%b, expected 0 0 0 0 reached=1",
               rvalid, arready, awready, rdata, n < 50);
    end
    rready = 0;
    @(negedge clk);
    rst = 0;
    #1;
    n_checks++;
    if (arready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_release: got arready=%b, expected 1", arready);
    end
    @(negedge clk);
    do_read(32'h100, 4'h3, 3, 2'b01, 3'd2, 0, dq, rq, lq, orid, lat, unst, tmo);
    n_checks++;
    if (tmo || dq.size() != 4) begin
      n_fail++;
      $display("FAIL reset_mid_newread: got beats=%0d tmo=%b, expected beats=4", dq.size(), tmo);
    end
    check_read("reset_mid_newread", 32'h100, 3, 2'b01, 3'd2, dq, rq, lq);
  endtask

  task automatic test_range;
    logic [31:0] d[$], dq[$];
    logic [3:0]  s[$];
    logic [1:0]  er, resp, rq[$];
    logic        lq[$];
    logic [3:0]  ob, orid;
    int lat, unst;
    bit tmo;
    d = '{32'h5A5A0001, 32'h5A5A0002}; s = '{4'hF, 4'hF};
    model_write(32'h3FFC, 1, 2'b01, 3'd2, d, s, 1, er);
    do_write(32'h3FFC, 4'hC, 1, 2'b01, 3'd2, d, s, 1, resp, ob, tmo);
    do_read(32'h3FFC, 4'hC, 1, 2'b01, 3'd2, 0, dq, rq, lq, orid, lat, unst, tmo);
`ifdef AXI_MEM_RANGE_CHECK_EN
    n_checks++;
    if (tmo || resp !== 2'b11 || dq.size() != 2 || dq[0] !== 32'h5A5A0001 || rq[0] !== 2'b00
        || dq[1] !== 32'h0 || rq[1] !== 2'b11) begin
      n_fail++;
      $display("FAIL range_decerr: got bresp=%0d beats=%0d tmo=%b, expected bresp=3 beat0=5a5a0001/OKAY beat1=0/DECERR",
               resp, dq.size(), tmo);
    end
`else
    n_checks++;
    if (tmo || resp !== 2'b00 || dq.size() != 2 || dq[0] !== 32'h5A5A0001 || dq[1] !== 32'h5A5A0002) begin
      n_fail++;
      $display("FAIL range_wrap: got bresp=%0d beats=%0d tmo=%b, expected bresp=0 data 5a5a0001 5a5a0002",
               resp, dq.size(), tmo);
    end
`endif
    check_read("range_readback", 32'h3FFC, 1, 2'b01, 3'd2, dq, rq, lq);
  endtask

  task automatic test_random;
    logic [31:0] d[$], dq[$], addr;
    logic [3:0]  s[$];
    logic [1:0]  er, resp, rq[$], burst;
    logic        lq[$];
    logic [3:0]  ob, orid, id;
    logic [2:0]  size;
    int len, last_at, lat, unst;
    bit tmo;
    for (int it = 0; it < 10; it++) begin
      len   = $urandom_range(0, 31);
      burst = 2'($urandom_range(0, 2));
      size  = 3'($urandom_range(0, 2));
      addr  = 32'($urandom_range(0, 32'h3FFF)) & ~((32'd1 << size) - 32'd1);
      id    = 4'($urandom);
      last_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 1) : len;
      d = {}; s = {};
      for (int i = 0; i <= len; i++) begin d.push_back($urandom); s.push_back(4'($urandom)); end
      model_write(addr, len, burst, size, d, s, last_at, er);
      do_write(addr, id, len, burst, size, d, s, last_at, resp, ob, tmo);
      n_checks++;
      if (tmo || resp !== er || ob !== id) begin
        n_fail++;
        $display("FAIL random_write_%0d: got bresp=%0d bid=%0d tmo=%b, expected bresp=%0d bid=%0d", it, resp, ob, tmo, er, id);
      end
      do_read(addr, id, len, burst, size, 2, dq, rq, lq, orid, lat, unst, tmo);
      n_checks++;
      if (tmo || unst != 0 || orid !== id || dq.size() != len + 1) begin
        n_fail++;
        $display("FAIL random_read_%0d: got beats=%0d rid=%0d unstable=%0d tmo=%b, expected beats=%0d rid=%0d unstable=0",
                 it, dq.size(), orid, unst, tmo, len + 1, id);
      end
      check_read("random_read", addr, len, burst, size, dq, rq, lq);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_incr_burst();
    test_strobe();
    test_fixed_and_slverr();
    test_back_to_back();
    test_reset_mid_burst();
    test_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 subordinate (responder) backed by an on-chip word-addressed memory: answers the AR/R and AW/W/B channels that the AXI adapter drives as initiator.
- Serves as the DDR stand-in for simulation and standalone FPGA bring-up of the DMA and accelerator datapaths.
- Independent read and write engines, each with one outstanding transaction; INCR and FIXED bursts up to 256 beats.

Parameters:
- AXI_AWIDTH, 32, address width
- AXI_DWIDTH, 32, data width; only 32 is supported
- MEM_AWIDTH, 12, log2 of memory depth in words (default 4096 words = 16 KiB)

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- arid  in  4; araddr  in  AXI_AWIDTH; arvalid  in  1; arready  out  1; arlen  in  8; arsize  in  3; arburst  in  2
- rid  out  4; rdata  out  AXI_DWIDTH; rvalid  out  1; rready  in  1; rlast  out  1; rresp  out  2
- awid  in  4; awaddr  in  AXI_AWIDTH; awvalid  in  1; awready  out  1; awlen  in  8; awsize  in  3; awburst  in  2
- wid  in  4 (ignored); wdata  in  AXI_DWIDTH; wvalid  in  1; wready  out  1; wlast  in  1; wstrb  in  AXI_DWIDTH/8
- bid  out  4; bresp  out  2; bvalid  out  1; bready  in  1

Behaviour:
- Reset:
  - All outputs are 0 while rst is high: valids, readys, rdata, rid, bid, rresp, bresp, rlast.
  - Both FSMs return to IDLE asynchronously, including mid-burst.
  - In-flight beats are discarded; memory contents are not cleared.
- Addressing:
  - Memory word index = addr[MEM_AWIDTH+1:2]; upper address bits are ignored, so addresses wrap modulo memory size.
  - Beat address step = 1<<size for INCR (2'b01) and for WRAP (2'b10, treated as INCR); step 0 for FIXED (2'b00).
  - Narrow sizes always use the full word lane at the current index.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1. On awvalid&awready, latch id/addr/len/size/burst, clear the beat count, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes wdata bytes whose wstrb bit is set, advances the address, and increments the count.
  - When count==awlen on a handshake, go to W_RESP.
  - Protocol error: wlast mismatching (count==awlen) on any beat sets a sticky SLVERR (2'b10). Completion always occurs at count==awlen regardless of wlast.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY (2'b00) or SLVERR. Hold until bready, then W_IDLE. bvalid is never dropped without bready.
  - awready=0 outside W_IDLE; wready=0 outside W_DATA.
- Read FSM (R_IDLE, R_FETCH, R_DATA):
  - R_IDLE: arready=1. On handshake, latch fields and go to R_FETCH.
  - R_FETCH: register rdata=mem[addr], advance address, go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rresp=OKAY, rlast=(count==arlen).
  - On rvalid&rready: if last, go to R_IDLE; otherwise load the next word into rdata on the same edge and stay in R_DATA (back-to-back beats).
  - rdata/rlast are stable while rvalid&~rready.
- Latency and throughput:
  - First rvalid is 2 cycles after the AR handshake.
  - Read throughput is 1 beat/cycle under continuous rready.
  - Write throughput is 1 beat/cycle.
- Simultaneous events:
  - Read and write engines run concurrently.
  - A same-cycle write and read-fetch of one word returns old data.
  - A new AR/AW is accepted the cycle after the previous transaction completes (IDLE).

Optional Feature:
- Macro: AXI_MEM_RANGE_CHECK_EN.
- With the macro: any beat whose address >= 4<<MEM_AWIDTH is out of range.
  - Out-of-range write beats are dropped and make bresp DECERR (2'b11); DECERR overrides SLVERR.
  - Out-of-range read beats return rdata=0 with rresp=DECERR for that beat only.
- Without the macro: addresses wrap as above; responses are only OKAY or SLVERR.

Decomposition:
- Package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR/DECERR constants, and the FSM state typedefs.
- Sub-module axi_mem_bank:
  - one byte-enabled write port and one combinational read port;
  - depth 2^MEM_AWIDTH words;
  - instantiated once and shared by both engines.

Test Plan:
- AW addr 0x100, len 3, INCR, size 2; W 0xA0..0xA3 with wlast on beat 3 -> bresp OKAY, bid echoed. AR of the same range -> rdata A0,A1,A2,A3, rlast on the 4th beat only, first rvalid 2 cycles after the AR handshake.
- Write 0x11223344 to 0x40, then wstrb 4'b0010 with data 0x0000FF00 -> read 0x40 returns 0x1122FF44.
- FIXED burst, len 2, to 0x80 with data 1,2,3 -> read 0x80 returns 3. Write of len 1 with wlast on beat 0 -> bresp SLVERR.
- Read len 7 with rready toggling 1010... -> each word held stable until accepted; 8 beats in order, no loss or duplication. Same test with a concurrent write burst -> both complete.
- Assert rst mid read burst (beat 2 of 8) -> rvalid/arready low immediately; after release arready=1 and a new read returns correct data.
- With AXI_MEM_RANGE_CHECK_EN, MEM_AWIDTH=12: write len 1 to 0x3FFC -> beat 1 dropped, bresp DECERR. Read of the same range -> beat 0 OKAY with data, beat 1 rdata=0 with DECERR.
